mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/doom_arb_pkg.sv | 20 ++
 rtl/rr_priority_picker.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/doom_arb_pkg.sv
// doom_arb_pkg: shared types and constants for the memory-port arbiter.
// Contents: the arbiter FSM state type, the default requester count and the
// command encoding used by the handlers.
package doom_arb_pkg;

    localparam int N_REQ_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        OWNED,
        DRAIN
    } arb_state_e;

    typedef enum logic [1:0] {
        CMD_NOP,
        CMD_READ,
        CMD_WRITE
    } cmd_e;

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin winner selection.
// Ports:
//   req        - request vector, one bit per requester
//   last_owner - index of the previous owner; the search starts just above it
//   onehot     - one-hot winner (all zero when nothing is requested)
//   idx        - winner index
//   any        - at least one request present
module rr_priority_picker
    import doom_arb_pkg::*;
#(
    parameter int N  = N_REQ_DEF,
    parameter int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last_owner,
    output logic [N-1:0]  onehot,
    output logic [LW-1:0] idx,
    output logic          any
);

    int j;

    // Walk from the farthest offset down to the nearest one so the requester
    // closest above last_owner is the final assignment and therefore wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = |req;
        j      = 0;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(last_owner) + k) % N]) begin
                j      = (int'(last_owner) + k) % N;
                onehot = '0;
                onehot[j] = 1'b1;
                idx    = LW'(j);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one memory master among N_REQ requesters.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   req_valid           - requester wants (and while high, keeps) the bus
//   req_address/read/write/writedata - packed per-requester master signals
//   req_waitrequest     - per-requester stall (always 1 for non-owners)
//   req_readdata        - slave read data broadcast to everyone
//   grant               - registered one-hot owner
//   busy                - bus is owned (OWNED or DRAIN)
//   mem_*               - shared master towards the slave
module mem_port_arbiter
    import doom_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int AW    = 32,
    parameter int DW    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*AW-1:0] req_address,
    input  logic [N_REQ-1:0]    req_read,
    input  logic [N_REQ-1:0]    req_write,
    input  logic [N_REQ*DW-1:0] req_writedata,
    output logic [N_REQ-1:0]    req_waitrequest,
    output logic [DW-1:0]       req_readdata,
    output logic [N_REQ-1:0]    grant,
    output logic                busy,
    output logic [AW-1:0]       mem_address,
    output logic                mem_read,
    output logic                mem_write,
    output logic [DW-1:0]       mem_writedata,
    input  logic                mem_waitrequest,
    input  logic [DW-1:0]       mem_readdata
);

    localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e       state;
    logic [LW-1:0]    last_owner;
    logic [LW-1:0]    win_idx;
    logic [N_REQ-1:0] win_hot;
    logic             win_any;
    logic             owned;
    logic             o_valid;
    logic             o_read;
    logic             o_write;
    logic [AW-1:0]    o_address;
    logic [DW-1:0]    o_writedata;

    rr_priority_picker #(.N(N_REQ), .LW(LW)) u_pick (
        .req        (req_valid),
        .last_owner (last_owner),
        .onehot     (win_hot),
        .idx        (win_idx),
        .any        (win_any)
    );

    // last_owner doubles as the current owner index while the bus is held.
    assign owned       = state != IDLE;
    assign o_valid     = req_valid[last_owner];
    assign o_read      = req_read[last_owner];
    assign o_write     = req_write[last_owner];
    assign o_address   = req_address[last_owner*AW +: AW];
    assign o_writedata = req_writedata[last_owner*DW +: DW];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_owner <= LW'(N_REQ - 1);
        end else begin
            case (state)
                IDLE: if (win_any) begin
                    state      <= OWNED;
                    grant      <= win_hot;
                    last_owner <= win_idx;
                end
                // A stalled transfer must still finish after the owner lets go.
                OWNED: if (!o_valid) begin
                    if ((o_read || o_write) && mem_waitrequest) begin
                        state <= DRAIN;
                    end else begin
                        state <= IDLE;
                        grant <= '0;
                    end
                end
                DRAIN: if (!mem_waitrequest) begin
                    state <= IDLE;
                    grant <= '0;
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    always_comb begin
        req_waitrequest = '1;
        if (owned) req_waitrequest[last_owner] = mem_waitrequest;
    end

    assign busy          = owned;
    assign req_readdata  = mem_readdata;
    assign mem_address   = owned ? o_address : '0;
    assign mem_writedata = owned ? o_writedata : '0;
    // Strobes are gated by reset directly so an abandoned transfer stops at once.
    assign mem_read      = owned && !reset && o_read;
    assign mem_write     = owned && !reset && o_write;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

    localparam int N = 4, AW = 32, DW = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_address = '0;
    logic [N-1:0]    req_read = '0;
    logic [N-1:0]    req_write = '0;
    logic [N*DW-1:0] req_writedata = '0;
    logic [N-1:0]    req_waitrequest;
    logic [DW-1:0]   req_readdata;
    logic [N-1:0]    grant;
    logic            busy;
    logic [AW-1:0]   mem_address;
    logic            mem_read;
    logic            mem_write;
    logic [DW-1:0]   mem_writedata;
    logic            mem_waitrequest = 1'b0;
    logic [DW-1:0]   mem_readdata = '0;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_address     (req_address),
        .req_read        (req_read),
        .req_write       (req_write),
        .req_writedata   (req_writedata),
        .req_waitrequest (req_waitrequest),
        .req_readdata    (req_readdata),
        .grant           (grant),
        .busy            (busy),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_writedata   (mem_writedata),
        .mem_waitrequest (mem_waitrequest),
        .mem_readdata    (mem_readdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic rd, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i] = v;
        req_read[i]  = rd;
        req_write[i] = wr;
        req_address[i*AW +: AW]   = a;
        req_writedata[i*DW +: DW] = d;
    endtask

    initial begin
        tick();
        tick();
        settle();
        check("rst_grant", 64'(grant), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_wait", 64'(req_waitrequest), 64'hf);
        check("rst_read", 64'(mem_read), 64'h0);
        reset = 1'b0;

        // single request from requester 1
        tick();
        set_req(1, 1'b1, 1'b1, 1'b0, 32'h100, 8'h00);
        mem_readdata    = 8'h5A;
        mem_waitrequest = 1'b1;
        settle();
        check("idle_grant", 64'(grant), 64'h0);
        check("idle_read", 64'(mem_read), 64'h0);
        check("idle_addr", 64'(mem_address), 64'h0);
        check("idle_rdata", 64'(req_readdata), 64'h5A);
        tick();
        settle();
        check("s_grant", 64'(grant), 64'h2);
        check("s_busy", 64'(busy), 64'h1);
        check("s_addr", 64'(mem_address), 64'h100);
        check("s_read", 64'(mem_read), 64'h1);
        check("s_wait_stall", 64'(req_waitrequest), 64'hf);
        mem_waitrequest = 1'b0;
        settle();
        check("s_wait_go", 64'(req_waitrequest), 64'hd);
        check("s_rdata", 64'(req_readdata), 64'h5A);
        set_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
        tick();
        settle();
        check("s_rel_grant", 64'(grant), 64'h0);
        check("s_rel_busy", 64'(busy), 64'h0);

        // contention after reset: 0,1,2,3 with an IDLE cycle between
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_valid = 4'hf;
        for (int k = 0; k < 4; k++) begin
            tick();
            settle();
            check("rr_grant", 64'(grant), 64'(1 << k));
            req_valid[k] = 1'b0;
            tick();
            settle();
            check("rr_gap_busy", 64'(busy), 64'h0);
            check("rr_gap_grant", 64'(grant), 64'h0);
            req_valid = 4'hf;
        end

        // wrap: last owner 3, requesters 0 and 3 both valid
        req_valid = 4'b1001;
        tick();
        settle();
        check("wrap_grant", 64'(grant), 64'h1);

        // isolation: owner 0 writes, requester 3 writes but must not leak
        set_req(0, 1'b1, 1'b0, 1'b1, 32'hA0, 8'h11);
        set_req(3, 1'b1, 1'b0, 1'b1, 32'hB3, 8'h33);
        settle();
        check("iso_write", 64'(mem_write), 64'h1);
        check("iso_wdata", 64'(mem_writedata), 64'h11);
        check("iso_addr", 64'(mem_address), 64'hA0);
        check("iso_wait3", 64'(req_waitrequest[3]), 64'h1);
        req_write[0] = 1'b0;
        settle();
        check("iso_write_off", 64'(mem_write), 64'h0);
        check("iso_wait3_b", 64'(req_waitrequest[3]), 64'h1);
        set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
        tick();
        settle();
        check("iso_idle_write", 64'(mem_write), 64'h0);
        check("iso_idle_grant", 64'(grant), 64'h0);
        tick();
        settle();
        check("iso_g3", 64'(grant), 64'h8);
        check("iso_g3_write", 64'(mem_write), 64'h1);
        check("iso_g3_wdata", 64'(mem_writedata), 64'h33);
        set_req(3, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
        tick();
        settle();
        check("iso_rel", 64'(grant), 64'h0);

        // drain: owner 2 drops valid mid-write while the slave stalls
        set_req(2, 1'b1, 1'b0, 1'b1, 32'hC2, 8'h77);
        mem_waitrequest = 1'b1;
        tick();
        settle();
        check("dr_grant", 64'(grant), 64'h4);
        check("dr_wait", 64'(req_waitrequest), 64'hf);
        req_valid[2] = 1'b0;
        req_valid[0] = 1'b1;
        settle();
        check("dr_w1", 64'(mem_write), 64'h1);
        tick();
        settle();
        check("dr_busy", 64'(busy), 64'h1);
        check("dr_grant_hold", 64'(grant), 64'h4);
        check("dr_w2", 64'(mem_write), 64'h1);
        check("dr_addr", 64'(mem_address), 64'hC2);
        tick();
        settle();
        check("dr_grant_hold2", 64'(grant), 64'h4);
        check("dr_w3", 64'(mem_write), 64'h1);
        mem_waitrequest = 1'b0;
        settle();
        check("dr_wait_go", 64'(req_waitrequest), 64'hb);
        tick();
        settle();
        check("dr_idle_busy", 64'(busy), 64'h0);
        check("dr_idle_grant", 64'(grant), 64'h0);
        check("dr_idle_write", 64'(mem_write), 64'h0);
        set_req(2, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
        set_req(0, 1'b1, 1'b1, 1'b0, 32'hD0, 8'h00);
        tick();
        settle();
        check("dr_next", 64'(grant), 64'h1);

        // reset in the middle of a stalled read
        mem_waitrequest = 1'b1;
        settle();
        check("rr_read_on", 64'(mem_read), 64'h1);
        reset = 1'b1;
        settle();
        check("rr_read_kill", 64'(mem_read), 64'h0);
        check("rr_grant_reg", 64'(grant), 64'h1);
        tick();
        settle();
        check("rr_rst_grant", 64'(grant), 64'h0);
        check("rr_rst_busy", 64'(busy), 64'h0);
        reset = 1'b0;
        req_valid = 4'hf;
        tick();
        settle();
        check("rr_first", 64'(grant), 64'h1);
        check("rr_first_read", 64'(mem_read), 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
